hyper_ca_sequencer: RTL and testbench
=====================================

Name: hyper_ca_sequencer

Overview:
- Downstream neighbour of the command/address generator in the uDMA HyperBus/PSRAM controller.
- Accepts one 48-bit command/address (CA) word per transaction and serialises it toward the PHY.
  - x8 devices: 16 bits per clock, one byte per CK edge.
  - x16 PSRAM: 32 bits per clock.
- Runs the initial-latency counter, then signals that the data phase may start.
- Holds chip-select low until the data stage releases it.

Parameters:
- LAT_W, 5, width of the latency-cycle configuration field.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- ca_valid_i  in  1  CA word valid
- ca_ready_o  out  1  sequencer can accept a CA word
- cmd_addr_i  in  48  command/address word from the generator
- mem_sel_i  in  2  00 HyperRAM, 01 HyperFlash, 10 PSRAM x8, 11 PSRAM x16
- lat_cycles_i  in  LAT_W  base initial latency in clocks
- fixed_lat_i  in  1  HyperRAM fixed latency: always use 2x
- skip_lat_i  in  1  zero-latency transaction (e.g. register write)
- rwds_i  in  1  synchronised RWDS from the PHY
- cs_release_i  in  1  data stage finished; deassert CS
- abort_i  in  1  synchronous abort
- ca_data_o  out  32  CA beat; x8 uses [15:0], x16 uses [31:0]
- ca_oe_o  out  1  ca_data_o valid / drive DQ
- ca_half_o  out  1  only [31:16] meaningful (last x16 beat)
- cs_n_o  out  1  chip-select, active low
- lat_done_o  out  1  one-cycle pulse: data phase may begin
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous, rst_ni low):
  - state IDLE, ca_ready_o=1, cs_n_o=1.
  - ca_oe_o=0, ca_half_o=0, lat_done_o=0, busy_o=0, ca_data_o=0.
  - All counters 0.
- States: IDLE, CA, LAT, HOLD.
- IDLE:
  - ca_ready_o=1.
  - On ca_valid_i & ca_ready_o, register cmd_addr_i, mem_sel_i, lat_cycles_i, fixed_lat_i and skip_lat_i, then go to CA.
  - Later input changes have no effect on the transaction.
- CA:
  - cs_n_o=0 from the first CA cycle. ca_oe_o=1 every CA cycle.
  - Beat count: 3 beats for mem_sel 00/01/10; 2 beats for 11.
  - x8 beats on ca_data_o[15:0], upper bits 0: CA[47:32], CA[31:16], CA[15:0].
  - x16 beats: CA[47:16], then {CA[15:0],16'h0} with ca_half_o=1.
  - The beat counter is 2 bits. Its max value is 2 (x8) or 1 (x16).
- HyperRAM variable latency (mem_sel 00 only):
  - Sample rwds_i during CA beat 0.
  - Effective latency = 2*lat_cycles_i if (fixed_lat_i | sampled rwds); otherwise lat_cycles_i.
  - Other mem_sel values always use lat_cycles_i.
  - Arithmetic is done in LAT_W+1 bits, so there is no overflow.
- After the last CA beat:
  - If skip_lat or effective latency==0: go to HOLD and pulse lat_done_o in the first HOLD cycle.
  - Otherwise go to LAT.
- LAT:
  - Down-counter loaded with effective latency − 1 on entry.
  - ca_oe_o=0, cs_n_o=0.
  - When the counter reaches 0, go to HOLD and pulse lat_done_o in the first HOLD cycle.
  - Latency N therefore gives exactly N LAT cycles.
- HOLD:
  - cs_n_o=0.
  - On cs_release_i: go to IDLE; cs_n_o=1 and ca_ready_o=1 in the next cycle.
  - cs_release_i is ignored in every state except HOLD.
- abort_i (any non-IDLE state):
  - Go to IDLE next cycle; cs_n_o=1, ca_oe_o=0, no lat_done_o pulse.
  - If abort_i and cs_release_i are high together, the outcome is identical.
- Back-to-back transactions: a new CA is accepted in the first IDLE cycle. The minimum CS-high time is therefore 1 clock.
- All outputs are registered (state-decoded from flops). First CA beat appears the cycle after acceptance.

Test Plan:
- HyperRAM read, CA=48'hA000_1234_0005, lat=6, rwds=0 -> beats 16'hA000, 16'h1234, 16'h0005 on 3 consecutive cycles, then 6 LAT cycles, then lat_done pulse, cs_n low throughout.
- Same transaction with rwds=1 at beat 0 (or fixed_lat_i=1) -> 12 LAT cycles before lat_done; PSRAM x8 with rwds=1 -> still 6.
- PSRAM x16, CA=48'h2021_8000_0010 -> beat0 32'h2021_8000 half=0, beat1 32'h0010_0000 half=1, then latency.
- Register write, skip_lat_i=1 -> 3 CA beats, lat_done in next cycle; lat=0 gives identical timing.
- abort_i during LAT cycle 2 -> IDLE next cycle, cs_n=1, no lat_done, ca_ready=1; the following transaction runs normally.
- Async reset asserted mid-CA -> all outputs at reset values immediately; cs_release_i pulsed in IDLE and abort_i in IDLE -> no state change.

Source files
------------

// File: rtl/hyper_ca_sequencer.sv
// hyper_ca_sequencer
// Takes one 48-bit command/address word per transaction from the CA
// generator, serialises it toward the PHY (16 bits per clock for x8 parts,
// 32 bits per clock for x16 PSRAM), runs the initial-latency countdown,
// pulses lat_done_o when the data phase may start, and holds chip-select
// low until the data stage releases it.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   ca_valid_i/ca_ready_o CA word handshake
//   cmd_addr_i            48-bit CA word
//   mem_sel_i             00 HyperRAM, 01 HyperFlash, 10 PSRAM x8, 11 PSRAM x16
//   lat_cycles_i          base initial latency in clocks
//   fixed_lat_i           HyperRAM fixed latency (always 2x)
//   skip_lat_i            zero-latency transaction
//   rwds_i                synchronised RWDS (HyperRAM latency request)
//   cs_release_i          data stage finished, deassert CS
//   abort_i               synchronous abort back to idle
//   ca_data_o/ca_oe_o     CA beat and its drive enable
//   ca_half_o             only [31:16] meaningful (last x16 beat)
//   cs_n_o                chip-select, active low
//   lat_done_o            one-cycle pulse: data phase may begin
//   busy_o                transaction in progress
module hyper_ca_sequencer #(
  parameter int unsigned LAT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ca_valid_i,
  output logic             ca_ready_o,
  input  logic [47:0]      cmd_addr_i,
  input  logic [1:0]       mem_sel_i,
  input  logic [LAT_W-1:0] lat_cycles_i,
  input  logic             fixed_lat_i,
  input  logic             skip_lat_i,
  input  logic             rwds_i,
  input  logic             cs_release_i,
  input  logic             abort_i,
  output logic [31:0]      ca_data_o,
  output logic             ca_oe_o,
  output logic             ca_half_o,
  output logic             cs_n_o,
  output logic             lat_done_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_HOLD
  } state_t;

  localparam logic [LAT_W:0] LAT_ONE = (LAT_W+1)'(1);

  state_t           state_q;
  logic [47:0]      ca_q;
  logic [1:0]       sel_q;
  logic [LAT_W-1:0] lat_q;
  logic             fixed_q;
  logic             skip_q;
  logic             rwds_q;
  logic [1:0]       beat_q;
  logic [LAT_W:0]   cnt_q;

  logic             x16;
  logic             last_beat;
  logic [LAT_W:0]   eff_lat;

  // {half, data} for a given beat of a CA word.
  function automatic logic [32:0] beat_word(input logic [47:0] ca,
                                            input logic        wide,
                                            input logic [1:0]  beat);
    logic [32:0] w;
    w = '0;
    if (wide) begin
      if (beat == 2'd0) w = {1'b0, ca[47:16]};
      else              w = {1'b1, ca[15:0], 16'h0000};
    end else begin
      case (beat)
        2'd0:    w = {1'b0, 16'h0000, ca[47:32]};
        2'd1:    w = {1'b0, 16'h0000, ca[31:16]};
        default: w = {1'b0, 16'h0000, ca[15:0]};
      endcase
    end
    return w;
  endfunction

  always_comb begin
    x16       = (sel_q == 2'b11);
    last_beat = x16 ? (beat_q == 2'd1) : (beat_q == 2'd2);
    // Doubling only applies to HyperRAM; rwds_q was captured during beat 0,
    // which always precedes the last beat.
    eff_lat   = {1'b0, lat_q};
    if ((sel_q == 2'b00) && (fixed_q || rwds_q)) eff_lat = {lat_q, 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ca_q       <= '0;
      sel_q      <= '0;
      lat_q      <= '0;
      fixed_q    <= 1'b0;
      skip_q     <= 1'b0;
      rwds_q     <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
      ca_ready_o <= 1'b1;
      cs_n_o     <= 1'b1;
      ca_oe_o    <= 1'b0;
      ca_half_o  <= 1'b0;
      ca_data_o  <= '0;
      lat_done_o <= 1'b0;
      busy_o     <= 1'b0;
    end else if ((state_q != ST_IDLE) && abort_i) begin
      state_q    <= ST_IDLE;
      ca_ready_o <= 1'b1;
      cs_n_o     <= 1'b1;
      ca_oe_o    <= 1'b0;
      ca_half_o  <= 1'b0;
      ca_data_o  <= '0;
      lat_done_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ca_valid_i && ca_ready_o) begin
            ca_q       <= cmd_addr_i;
            sel_q      <= mem_sel_i;
            lat_q      <= lat_cycles_i;
            fixed_q    <= fixed_lat_i;
            skip_q     <= skip_lat_i;
            beat_q     <= '0;
            state_q    <= ST_CA;
            ca_ready_o <= 1'b0;
            cs_n_o     <= 1'b0;
            ca_oe_o    <= 1'b1;
            busy_o     <= 1'b1;
            // Beat 0 is built straight from the inputs so it is on the
            // outputs the cycle after acceptance.
            {ca_half_o, ca_data_o} <= beat_word(cmd_addr_i, mem_sel_i == 2'b11, 2'd0);
          end
        end

        ST_CA: begin
          if (beat_q == 2'd0) rwds_q <= rwds_i;
          if (last_beat) begin
            ca_oe_o   <= 1'b0;
            ca_half_o <= 1'b0;
            ca_data_o <= '0;
            if (skip_q || (eff_lat == '0)) begin
              state_q    <= ST_HOLD;
              lat_done_o <= 1'b1;
            end else begin
              state_q <= ST_LAT;
              cnt_q   <= eff_lat - LAT_ONE;
            end
          end else begin
            beat_q <= beat_q + 2'd1;
            {ca_half_o, ca_data_o} <= beat_word(ca_q, x16, beat_q + 2'd1);
          end
        end

        ST_LAT: begin
          if (cnt_q == '0) begin
            state_q    <= ST_HOLD;
            lat_done_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q - LAT_ONE;
          end
        end

        ST_HOLD: begin
          lat_done_o <= 1'b0;
          if (cs_release_i) begin
            state_q    <= ST_IDLE;
            ca_ready_o <= 1'b1;
            cs_n_o     <= 1'b1;
            busy_o     <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_ca_sequencer.sv
// Self-checking bench for hyper_ca_sequencer: directed table of
// transactions, hand-written reset/abort/idle sequences, and randomized
// transactions checked against a transaction-level reference model.
module tb_hyper_ca_sequencer;

  localparam int unsigned LAT_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             ca_valid_i;
  logic             ca_ready_o;
  logic [47:0]      cmd_addr_i;
  logic [1:0]       mem_sel_i;
  logic [LAT_W-1:0] lat_cycles_i;
  logic             fixed_lat_i;
  logic             skip_lat_i;
  logic             rwds_i;
  logic             cs_release_i;
  logic             abort_i;
  logic [31:0]      ca_data_o;
  logic             ca_oe_o;
  logic             ca_half_o;
  logic             cs_n_o;
  logic             lat_done_o;
  logic             busy_o;

  int total_checks = 0;
  int bad_checks   = 0;

  hyper_ca_sequencer #(.LAT_W(LAT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ca_valid_i   (ca_valid_i),
    .ca_ready_o   (ca_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .mem_sel_i    (mem_sel_i),
    .lat_cycles_i (lat_cycles_i),
    .fixed_lat_i  (fixed_lat_i),
    .skip_lat_i   (skip_lat_i),
    .rwds_i       (rwds_i),
    .cs_release_i (cs_release_i),
    .abort_i      (abort_i),
    .ca_data_o    (ca_data_o),
    .ca_oe_o      (ca_oe_o),
    .ca_half_o    (ca_half_o),
    .cs_n_o       (cs_n_o),
    .lat_done_o   (lat_done_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [47:0]      ca;
    logic [1:0]       sel;
    logic [4:0]       lat;
    logic             fx;
    logic             sk;
    logic             rw;
    int               nb;
    logic [2:0][31:0] bt;
    logic [2:0]       hm;
    int               nlat;
    int               hold;
  } vec_t;

  // {ready, cs_n, oe, half, lat_done, busy, data}
  function automatic logic [37:0] mk(input logic rdy, csn, oe, half, ld, busy,
                                     input logic [31:0] data);
    return {rdy, csn, oe, half, ld, busy, data};
  endfunction

  function automatic vec_t mkv(input logic [47:0] ca, input logic [1:0] sel,
                               input logic [4:0] lat, input logic fx, sk, rw,
                               input int nb, input logic [31:0] b0, b1, b2,
                               input logic [2:0] hm, input int nlat, input int hold);
    vec_t v;
    v.ca = ca; v.sel = sel; v.lat = lat; v.fx = fx; v.sk = sk; v.rw = rw;
    v.nb = nb; v.bt[0] = b0; v.bt[1] = b1; v.bt[2] = b2; v.hm = hm;
    v.nlat = nlat; v.hold = hold;
    return v;
  endfunction

  // Transaction-level reference: which beats appear and how many latency
  // clocks follow them.
  task automatic model(input logic [47:0] ca, input logic [1:0] sel,
                       input logic [4:0] lat, input logic fx, sk, rw,
                       output int nb, output logic [2:0][31:0] bt,
                       output logic [2:0] hm, output int nlat);
    bt = '0;
    if (sel == 2'b11) begin
      nb = 2;
      bt[0] = ca[47:16];
      bt[1] = {ca[15:0], 16'h0000};
      hm = 3'b010;
    end else begin
      nb = 3;
      bt[0] = {16'h0000, ca[47:32]};
      bt[1] = {16'h0000, ca[31:16]};
      bt[2] = {16'h0000, ca[15:0]};
      hm = 3'b000;
    end
    if (sk)                            nlat = 0;
    else if (sel == 2'b00 && (fx || rw)) nlat = 2 * int'(lat);
    else                               nlat = int'(lat);
  endtask

  task automatic check(input string name, input int k, input logic [37:0] exp_v);
    logic [37:0] act;
    act = {ca_ready_o, cs_n_o, ca_oe_o, ca_half_o, lat_done_o, busy_o, ca_data_o};
    total_checks++;
    if (act !== exp_v) begin
      bad_checks++;
      $display("FAIL %s cyc=%0d got=%h want=%h (rdy,csn,oe,half,ld,busy,data)",
               name, k, act, exp_v);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a
  // negedge with the DUT idle again.
  task automatic run_txn(input string name, input vec_t v, input int abort_at,
                         input bit noise);
    int total;
    total = v.nb + v.nlat + v.hold;
    ca_valid_i   = 1'b1;
    cmd_addr_i   = v.ca;
    mem_sel_i    = v.sel;
    lat_cycles_i = v.lat;
    fixed_lat_i  = v.fx;
    skip_lat_i   = v.sk;
    rwds_i       = 1'($urandom);
    cs_release_i = 1'b0;
    abort_i      = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    // Scramble the inputs: the captured transaction must be unaffected.
    ca_valid_i   = 1'b0;
    cmd_addr_i   = {16'($urandom), $urandom};
    mem_sel_i    = 2'($urandom);
    lat_cycles_i = 5'($urandom);
    fixed_lat_i  = 1'($urandom);
    skip_lat_i   = 1'($urandom);
    for (int k = 0; k < total; k++) begin
      if (k < v.nb)
        check(name, k, mk(1'b0, 1'b0, 1'b1, v.hm[k], 1'b0, 1'b1, v.bt[k]));
      else if (k < v.nb + v.nlat)
        check(name, k, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
      else
        check(name, k, mk(1'b0, 1'b0, 1'b0, 1'b0, k == v.nb + v.nlat, 1'b1, 32'h0));
      rwds_i = (k == 0) ? v.rw : ~v.rw;
      if (k == abort_at) begin
        abort_i      = 1'b1;
        cs_release_i = 1'($urandom);
        @(posedge clk_i); @(negedge clk_i);
        abort_i      = 1'b0;
        cs_release_i = 1'b0;
        break;
      end
      if (k == total - 1)              cs_release_i = 1'b1;
      else if (noise && k < v.nb + v.nlat) cs_release_i = 1'($urandom);
      else                             cs_release_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
    end
    cs_release_i = 1'b0;
    check({name, "_idle"}, -1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = mkv(48'hA000_1234_0005, 2'b00, 5'd6,  1'b0, 1'b0, 1'b0, 3,
                 32'h0000_A000, 32'h0000_1234, 32'h0000_0005, 3'b000, 6, 1);
    tbl[1] = mkv(48'hA000_1234_0005, 2'b00, 5'd6,  1'b0, 1'b0, 1'b1, 3,
                 32'h0000_A000, 32'h0000_1234, 32'h0000_0005, 3'b000, 12, 2);
    tbl[2] = mkv(48'hA000_1234_0005, 2'b00, 5'd6,  1'b1, 1'b0, 1'b0, 3,
                 32'h0000_A000, 32'h0000_1234, 32'h0000_0005, 3'b000, 12, 1);
    tbl[3] = mkv(48'hA000_1234_0005, 2'b10, 5'd6,  1'b0, 1'b0, 1'b1, 3,
                 32'h0000_A000, 32'h0000_1234, 32'h0000_0005, 3'b000, 6, 1);
    tbl[4] = mkv(48'h2021_8000_0010, 2'b11, 5'd6,  1'b0, 1'b0, 1'b0, 2,
                 32'h2021_8000, 32'h0010_0000, 32'h0, 3'b010, 6, 3);
    tbl[5] = mkv(48'hC000_0100_0001, 2'b00, 5'd6,  1'b0, 1'b1, 1'b1, 3,
                 32'h0000_C000, 32'h0000_0100, 32'h0000_0001, 3'b000, 0, 1);
    tbl[6] = mkv(48'hC000_0100_0001, 2'b00, 5'd0,  1'b0, 1'b0, 1'b1, 3,
                 32'h0000_C000, 32'h0000_0100, 32'h0000_0001, 3'b000, 0, 1);
    tbl[7] = mkv(48'h1234_5678_9ABC, 2'b01, 5'd31, 1'b1, 1'b0, 1'b1, 3,
                 32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC, 3'b000, 31, 1);
    tbl[8] = mkv(48'hFFFF_0000_FFFF, 2'b00, 5'd31, 1'b1, 1'b0, 1'b0, 3,
                 32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF, 3'b000, 62, 1);

    rst_ni = 1'b0;
    ca_valid_i = 1'b0; cmd_addr_i = '0; mem_sel_i = '0; lat_cycles_i = '0;
    fixed_lat_i = 1'b0; skip_lat_i = 1'b0; rwds_i = 1'b0;
    cs_release_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset", 0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_idle", 0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

    // cs_release and abort in IDLE change nothing.
    cs_release_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    cs_release_i = 1'b0; abort_i = 1'b0;
    check("idle_release_abort", 0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

    for (int i = 0; i < 9; i++) run_txn($sformatf("tbl%0d", i), tbl[i], -1, 1'b0);

    // Abort during the second LAT cycle, then a normal transaction.
    run_txn("abort_lat2", tbl[0], 4, 1'b0);
    run_txn("after_abort", tbl[0], -1, 1'b0);

    // Asynchronous reset in the middle of the CA phase.
    ca_valid_i = 1'b1; cmd_addr_i = 48'hA000_1234_0005; mem_sel_i = 2'b00;
    lat_cycles_i = 5'd6;
    @(posedge clk_i);
    #2;
    ca_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_midca", 0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("after_async_reset", 0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

    for (int i = 0; i < 40; i++) begin
      int abort_at;
      rv.ca   = {16'($urandom), $urandom};
      rv.sel  = 2'($urandom);
      rv.lat  = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
      rv.fx   = 1'($urandom);
      rv.sk   = ($urandom % 4 == 0);
      rv.rw   = 1'($urandom);
      rv.hold = $urandom_range(1, 3);
      model(rv.ca, rv.sel, rv.lat, rv.fx, rv.sk, rv.rw, rv.nb, rv.bt, rv.hm, rv.nlat);
      abort_at = ($urandom % 5 == 0) ?
                 int'($urandom_range(0, rv.nb + rv.nlat + rv.hold - 1)) : -1;
      run_txn($sformatf("rand%0d", i), rv, abort_at, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
